// File: rtl/sm_seg_display_pkg.sv
// Shared definitions for the add/subtract result display: FSM states,
// conversion constants, segment patterns and the double-dabble step.
package sm_seg_display_pkg;

  localparam int unsigned MAG_W      = 5;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SHIFT_W    = 2 * BCD_W + MAG_W;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_N      = 4;
  localparam int unsigned DIG_IDX_W  = 2;
  localparam int unsigned ITER_W     = 3;
  localparam int unsigned CONV_ITERS = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam logic [BCD_W-1:0] CODE_MINUS = 4'd10;
  localparam logic [BCD_W-1:0] CODE_BLANK = 4'd15;

  // Active-high {g,f,e,d,c,b,a} patterns
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // One double-dabble iteration: adjust nibbles >=5 by +3, then shift left.
  function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] sr);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = sr[SHIFT_W-1 -: BCD_W];
    units = sr[MAG_W +: BCD_W];
    if (tens >= 4'd5)  tens  = tens + 4'd3;
    if (units >= 4'd5) units = units + 4'd3;
    return {tens, units, sr[MAG_W-1:0]} << 1;
  endfunction

endpackage

// File: rtl/sm_seg_display_seg7_encode.sv
// Combinational 7-segment encoder: digits 0-9, 10 = minus, 11-15 = blank.
module seg7_encode
  import sm_seg_display_pkg::*;
(
  input  logic [BCD_W-1:0] code_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
      4'd10:   seg_c_o = SEG_MINUS;
      default: seg_c_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sm_seg_display.sv
// Result formatter: accepts magnitude/sign, converts to BCD by iterative
// double-dabble, and scans sign/tens/units onto a 4-digit multiplexed display.
module sm_seg_display
  import sm_seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] mag,
  input  logic             sign,
  output logic             done,
  output logic [SEG_W-1:0] seg,
  output logic [DIG_N-1:0] an
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(CONV_ITERS - 1);

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   sr_q, sr_d, sr_next;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic                 neg_q, neg_d;
  logic                 in_ready_q, in_ready_d;
  logic                 done_q, done_d;
  logic [BCD_W-1:0]     disp_tens_q, disp_tens_d;
  logic [BCD_W-1:0]     disp_units_q, disp_units_d;
  logic                 disp_neg_q, disp_neg_d;

  logic [REF_W-1:0]     ref_cnt_q;
  logic [DIG_IDX_W-1:0] dig_idx_q;
  logic [BCD_W-1:0]     code_c;
  logic [SEG_W-1:0]     seg_raw_c;
  logic [SEG_W-1:0]     seg_q;
  logic [DIG_N-1:0]     an_q;

  function automatic logic [SEG_W-1:0] polarity(input logic [SEG_W-1:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      iter_q       <= '0;
      neg_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      disp_tens_q  <= '0;
      disp_units_q <= '0;
      disp_neg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      iter_q       <= iter_d;
      neg_q        <= neg_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      disp_tens_q  <= disp_tens_d;
      disp_units_q <= disp_units_d;
      disp_neg_q   <= disp_neg_d;
    end
  end

  // Accept/convert FSM; display registers change only at the last iteration.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    iter_d       = iter_q;
    neg_d        = neg_q;
    in_ready_d   = in_ready_q;
    done_d       = 1'b0;
    disp_tens_d  = disp_tens_q;
    disp_units_d = disp_units_q;
    disp_neg_d   = disp_neg_q;
    sr_next      = dd_step(sr_q);
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sr_d       = {{(2 * BCD_W){1'b0}}, mag};
          neg_d      = sign && (mag != '0);
          iter_d     = '0;
          in_ready_d = 1'b0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_d   = sr_next;
        iter_d = iter_q + 3'd1;
        if (iter_q == ITER_LAST) begin
          disp_tens_d  = sr_next[SHIFT_W-1 -: BCD_W];
          disp_units_d = sr_next[MAG_W +: BCD_W];
          disp_neg_d   = neg_q;
          done_d       = 1'b1;
          in_ready_d   = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running refresh timer selecting the lit digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      dig_idx_q <= '0;
    end else if (ref_cnt_q == REF_LAST) begin
      ref_cnt_q <= '0;
      dig_idx_q <= dig_idx_q + 2'd1;
    end else begin
      ref_cnt_q <= ref_cnt_q + REF_W'(1);
    end
  end

  always_comb begin
    code_c = CODE_BLANK;
    case (dig_idx_q)
      2'd0: code_c = disp_units_q;
      2'd1: code_c = (disp_tens_q == '0) ? CODE_BLANK : disp_tens_q;
      2'd2: code_c = disp_neg_q ? CODE_MINUS : CODE_BLANK;
      default: code_c = CODE_BLANK;
    endcase
  end

  seg7_encode u_seg7_encode (
    .code_i  (code_c),
    .seg_c_o (seg_raw_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'b1110;
      seg_q <= polarity(SEG_0);
    end else begin
      an_q  <= ~(4'b0001 << dig_idx_q);
      seg_q <= polarity(seg_raw_c);
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_sm_seg_display.sv
// Directed bench for sm_seg_display with REFRESH_DIV=4, active-low segments.
module tb_sm_seg_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] mag;
  logic       sign;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Active-low patterns, hand-inverted
  localparam logic [6:0] L_0 = 7'b1000000, L_1 = 7'b1111001, L_2 = 7'b0100100;
  localparam logic [6:0] L_3 = 7'b0110000, L_5 = 7'b0010010, L_6 = 7'b0000010;
  localparam logic [6:0] L_7 = 7'b1111000, L_8 = 7'b0000000, L_9 = 7'b0010000;
  localparam logic [6:0] L_MINUS = 7'b0111111, L_BLANK = 7'b1111111;

  typedef struct {
    logic [4:0] m;
    logic       s;
    logic [6:0] exp_units;
    logic [6:0] exp_tens;
    logic [6:0] exp_sign;
  } vec_t;

  vec_t vecs[6];

  sm_seg_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mag      (mag),
    .sign     (sign),
    .done     (done),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [4:0] m, input logic s);
    int lat = 0;
    in_valid = 1'b1;
    mag      = m;
    sign     = s;
    wait_ready();
    tick();
    in_valid = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("done_latency", 32'(lat), 32'd5);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Record the last segment value seen on each digit over a full scan.
  task automatic scan(output logic [3:0][6:0] d);
    d = '0;
    for (int i = 0; i < 4 * DIV; i++) begin
      tick();
      case (an)
        4'b1110: d[0] = seg;
        4'b1101: d[1] = seg;
        4'b1011: d[2] = seg;
        4'b0111: d[3] = seg;
        default: chk("an_onehot", 32'(an), 32'hE);
      endcase
    end
  endtask

  logic [3:0][6:0] dig;
  int              acc_prev;
  logic [4:0]      stream[3];
  logic [3:0]      st_tens[3];
  logic [3:0]      st_units[3];

  initial begin
    vecs[0] = '{5'd30, 1'b0, L_0, L_3, L_BLANK};
    vecs[1] = '{5'd7,  1'b1, L_7, L_BLANK, L_MINUS};
    vecs[2] = '{5'd0,  1'b1, L_0, L_BLANK, L_BLANK};
    vecs[3] = '{5'd19, 1'b0, L_9, L_1, L_BLANK};
    vecs[4] = '{5'd28, 1'b1, L_8, L_2, L_MINUS};
    vecs[5] = '{5'd16, 1'b0, L_6, L_1, L_BLANK};
    stream  = '{5'd31, 5'd5, 5'd12};
    st_tens = '{4'd3, 4'd0, 4'd1};
    st_units = '{4'd1, 4'd5, 4'd2};

    rst = 1'b1; in_valid = 1'b0; mag = '0; sign = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'(L_0));

    // Refresh scan: an after the k-th post-reset edge reflects digit (k-1)/4
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("scan_an", 32'(an), 32'(~(4'b0001 << ((k - 1) / 4)) & 4'hF));
      chk("scan_seg", 32'(seg), ((k - 1) / 4 == 0) ? 32'(L_0) : 32'(L_BLANK));
    end

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].m, vecs[i].s);
      scan(dig);
      chk("vec_units", 32'(dig[0]), 32'(vecs[i].exp_units));
      chk("vec_tens", 32'(dig[1]), 32'(vecs[i].exp_tens));
      chk("vec_sign", 32'(dig[2]), 32'(vecs[i].exp_sign));
      chk("vec_blank3", 32'(dig[3]), 32'(L_BLANK));
    end

    // Back-to-back stream with in_valid held high
    in_valid = 1'b1; sign = 1'b0; mag = stream[0];
    wait_ready();
    acc_prev = -1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc_prev >= 0) chk("stream_spacing", 32'(cyc - acc_prev), 32'd6);
      acc_prev = cyc;
      chk("stream_busy", 32'(in_ready), 32'd0);
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("stream_busy", 32'(in_ready), 32'd0);
      end
      tick();
      chk("stream_done", 32'(done), 32'd1);
      chk("stream_tens", 32'(dut.disp_tens_q), 32'(st_tens[i]));
      chk("stream_units", 32'(dut.disp_units_q), 32'(st_units[i]));
      if (i < 2) mag = stream[i + 1];
    end
    in_valid = 1'b0;
    tick();

    // Reset during the third CONV cycle of mag=25
    in_valid = 1'b1; mag = 5'd25; sign = 1'b1;
    wait_ready();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    chk("abort_tens", 32'(dut.disp_tens_q), 32'd0);
    chk("abort_units", 32'(dut.disp_units_q), 32'd0);
    scan(dig);
    chk("abort_units_seg", 32'(dig[0]), 32'(L_0));
    chk("abort_tens_seg", 32'(dig[1]), 32'(L_BLANK));
    chk("abort_sign_seg", 32'(dig[2]), 32'(L_BLANK));

    // Full conversion sweep
    for (int m = 0; m < 32; m++) begin
      send(5'(m), 1'b0);
      chk("sweep_tens", 32'(dut.disp_tens_q), 32'(m / 10));
      chk("sweep_units", 32'(dut.disp_units_q), 32'(m % 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
